// File: rtl/msrv32_branch_ctrl_if.sv
// Request and redirect handshake bundle between decode/fetch and the branch controller.
// The master side is decode+fetch and the slave side is the controller.
interface msrv32_branch_ctrl_if;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [4:0]  opcode_in;
    logic [2:0]  func3_in;
    logic [31:0] rs1_in;
    logic [31:0] rs2_in;
    logic [31:0] pc_in;
    logic [31:0] imm_in;
    logic        redirect_valid_out;
    logic        redirect_ready_in;
    logic [31:0] redirect_pc_out;

    modport master (
        output req_valid_in, opcode_in, func3_in, rs1_in, rs2_in, pc_in, imm_in,
        output redirect_ready_in,
        input  req_ready_out, redirect_valid_out, redirect_pc_out
    );

    modport slave (
        input  req_valid_in, opcode_in, func3_in, rs1_in, rs2_in, pc_in, imm_in,
        input  redirect_ready_in,
        output req_ready_out, redirect_valid_out, redirect_pc_out
    );
endinterface

// File: rtl/msrv32_branch_ctrl.sv
// Control-transfer sequencer: evaluates branch/JAL/JALR, holds redirects to fetch,
// reports not-taken/misaligned/illegal outcomes and keeps saturating perf counters.
//
// state      | meaning
// S_IDLE     | ready for a request, captures operands on req_valid_in
// S_EVAL     | condition, target and link computed from captured operands
// S_REDIRECT | redirect_valid held until fetch accepts
module msrv32_branch_ctrl #(
    parameter int unsigned CNT_W  = 16,
    parameter logic [31:0] RST_PC = 32'h0000_0000
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    msrv32_branch_ctrl_if.slave bus,
    output logic [31:0]        link_out,
    output logic               flush_out,
    output logic               done_out,
    output logic               taken_out,
    output logic               misaligned_out,
    output logic               illegal_out,
    input  logic               clear_cnt_in,
    output logic [CNT_W-1:0]   br_count_out,
    output logic [CNT_W-1:0]   taken_count_out
);
    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_REDIRECT} state_t;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_opcode;
    logic [2:0]  r_func3;
    logic [31:0] r_rs1, r_rs2, r_pc, r_imm;
    logic [31:0] r_redirect_pc, r_link;
    logic        r_done_nt, r_misaligned, r_illegal;
    logic [CNT_W-1:0] r_br_count, r_taken_count;

    logic        w_eq, w_ltu, w_lt, w_cond, w_illegal, w_misaligned, w_taken;
    logic [31:0] w_target;
    logic        w_handshake, w_req_ready, w_redirect_valid;

    assign w_eq  = (r_rs1 == r_rs2);
    assign w_ltu = (r_rs1 < r_rs2);
    // Differing sign bits decide a signed compare on their own.
    assign w_lt  = (r_rs1[31] != r_rs2[31]) ? r_rs1[31] : w_ltu;

    always_comb begin
        w_cond    = 1'b0;
        w_illegal = 1'b0;
        w_target  = r_pc + r_imm;
        case (r_opcode)
            OP_BRANCH: begin
                case (r_func3)
                    3'b000:  w_cond = w_eq;
                    3'b001:  w_cond = !w_eq;
                    3'b100:  w_cond = w_lt;
                    3'b101:  w_cond = !w_lt;
                    3'b110:  w_cond = w_ltu;
                    3'b111:  w_cond = !w_ltu;
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_JAL: w_cond = 1'b1;
            OP_JALR: begin
                w_target  = (r_rs1 + r_imm) & ~32'h0000_0001;
                w_cond    = (r_func3 == 3'b000);
                w_illegal = (r_func3 != 3'b000);
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_misaligned = w_cond && (w_target[1:0] != 2'b00);
    assign w_taken      = w_cond && !w_misaligned;

    always_comb begin
        w_state_nxt      = r_state;
        w_req_ready      = 1'b0;
        w_redirect_valid = 1'b0;
        w_handshake      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid_in) w_state_nxt = S_EVAL;
            end
            S_EVAL: w_state_nxt = w_taken ? S_REDIRECT : S_IDLE;
            S_REDIRECT: begin
                w_redirect_valid = 1'b1;
                w_handshake      = bus.redirect_ready_in;
                if (bus.redirect_ready_in) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= S_IDLE;
            r_opcode      <= '0;
            r_func3       <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_pc          <= '0;
            r_imm         <= '0;
            r_redirect_pc <= RST_PC;
            r_link        <= RST_PC;
            r_done_nt     <= 1'b0;
            r_misaligned  <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_done_nt    <= 1'b0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
            if (r_state == S_IDLE && bus.req_valid_in) begin
                r_opcode <= bus.opcode_in;
                r_func3  <= bus.func3_in;
                r_rs1    <= bus.rs1_in;
                r_rs2    <= bus.rs2_in;
                r_pc     <= bus.pc_in;
                r_imm    <= bus.imm_in;
            end
            // Non-redirect outcomes retire as a registered pulse alongside the new link.
            if (r_state == S_EVAL) begin
                r_link       <= r_pc + 32'd4;
                r_done_nt    <= !w_taken;
                r_misaligned <= w_misaligned;
                r_illegal    <= w_illegal;
                if (w_taken) r_redirect_pc <= w_target;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else if (clear_cnt_in) begin
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else begin
            if (done_out && !(&r_br_count))       r_br_count    <= r_br_count + CNT_W'(1);
            if (flush_out && !(&r_taken_count))   r_taken_count <= r_taken_count + CNT_W'(1);
        end
    end

    assign bus.req_ready_out      = w_req_ready;
    assign bus.redirect_valid_out = w_redirect_valid;
    assign bus.redirect_pc_out    = r_redirect_pc;
    assign link_out               = r_link;
    assign flush_out              = w_handshake;
    assign taken_out              = w_handshake;
    assign done_out               = r_done_nt | w_handshake;
    assign misaligned_out         = r_misaligned;
    assign illegal_out            = r_illegal;
    assign br_count_out           = r_br_count;
    assign taken_count_out        = r_taken_count;
endmodule
